// File: rtl/pipe_stage_hs_pkg.sv
// Shared definitions for the pipeline-stage register.
// Holds bus widths, IF/ID field offsets and the skid-buffer state encoding.
package pipe_stage_hs_pkg;

  // IF/ID bus packs {pc, pcnow, inst}
  localparam int unsigned IF2ID_BUS_SIZE  = 96;
  localparam int unsigned IF2ID_INST_LSB  = 0;
  localparam int unsigned IF2ID_PCNOW_LSB = 32;
  localparam int unsigned IF2ID_PC_LSB    = 64;

  typedef enum logic [1:0] {
    PIPE_S_EMPTY = 2'd0,
    PIPE_S_ONE   = 2'd1,
    PIPE_S_TWO   = 2'd2
  } pipe_skid_state_e;

endpackage

// File: rtl/pipe_stage_hs_skid.sv
// One-entry skid buffer controller for pipe_stage_hs (used when PIPE_SKID_EN is defined).
// Tracks occupancy of main register + skid entry, and tells the top when and
// from where to load the main output register. in_ready_o is a flop output.
module pipe_skid_buf
  import pipe_stage_hs_pkg::*;
#(
  parameter int unsigned WIDTH = 96
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             out_ready_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic             load_o,
  output logic [WIDTH-1:0] load_data_o
);

  pipe_skid_state_e r_state;
  pipe_skid_state_e w_next;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_skid;
  logic             w_skid_we;
  logic             w_in_xfer;
  logic             w_out_xfer;

  assign out_valid_o = (r_state != PIPE_S_EMPTY);
  assign in_ready_o  = r_in_ready;
  assign w_in_xfer   = in_valid_i & r_in_ready;
  assign w_out_xfer  = out_valid_o & out_ready_i;

  // Next-state, main-register load and skid-write decode.
  always_comb begin
    w_next      = r_state;
    w_skid_we   = 1'b0;
    load_o      = 1'b0;
    load_data_o = in_data_i;
    if (flush_i) begin
      w_next = PIPE_S_EMPTY;
    end else begin
      case (r_state)
        PIPE_S_EMPTY: begin
          if (w_in_xfer) begin
            load_o = 1'b1;
            w_next = PIPE_S_ONE;
          end
        end
        PIPE_S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            load_o = 1'b1;
          end else if (w_in_xfer) begin
            w_skid_we = 1'b1;
            w_next    = PIPE_S_TWO;
          end else if (w_out_xfer) begin
            w_next = PIPE_S_EMPTY;
          end
        end
        PIPE_S_TWO: begin
          if (w_out_xfer) begin
            load_o      = 1'b1;
            load_data_o = r_skid;
            w_next      = PIPE_S_ONE;
          end
        end
        default: w_next = PIPE_S_EMPTY;
      endcase
    end
  end

  // State register; in_ready is registered from the next state so that
  // out_ready_i has no combinational path to in_ready_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= PIPE_S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != PIPE_S_TWO);
    end
  end

  // Skid entry captures a beat accepted while the main register is stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_skid <= '0;
    end else if (w_skid_we) begin
      r_skid <= in_data_i;
    end
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// Generic pipeline-stage register with valid/ready handshake, synchronous
// flush and a saturating stall counter. Define PIPE_SKID_EN to add a
// one-entry skid buffer that makes in_ready_o a registered output.
module pipe_stage_hs
  import pipe_stage_hs_pkg::*;
#(
  parameter int unsigned      WIDTH   = IF2ID_BUS_SIZE,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int unsigned      CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic             w_load;
  logic [WIDTH-1:0] w_load_data;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_stall_cnt;

`ifdef PIPE_SKID_EN
  pipe_skid_buf #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .out_ready_i (out_ready_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .load_o      (w_load),
    .load_data_o (w_load_data)
  );
`else
  logic r_valid;
  logic w_in_xfer;
  logic w_out_xfer;

  assign in_ready_o  = ~r_valid | out_ready_i;
  assign out_valid_o = r_valid;
  assign w_in_xfer   = in_valid_i & in_ready_o;
  assign w_out_xfer  = r_valid & out_ready_i;
  assign w_load      = w_in_xfer & ~flush_i;
  assign w_load_data = in_data_i;

  // Valid flag: flush wins, a new beat sets it, a drained beat clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_in_xfer) begin
      r_valid <= 1'b1;
    end else if (w_out_xfer) begin
      r_valid <= 1'b0;
    end
  end
`endif

  // Main output register; only loaded on an accepted, non-flushed beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data <= RST_VAL;
    end else if (w_load) begin
      r_data <= w_load_data;
    end
  end

  // Saturating count of stalled cycles; flush does not touch it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (out_valid_o && !out_ready_i && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign out_data_o  = r_data;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed + randomized scoreboard bench for pipe_stage_hs.
// Honors PIPE_SKID_EN where skid-mode behaviour differs.
module tb_pipe_stage_hs;

  localparam int unsigned W = 96;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          in_valid_i;
  logic          out_ready_i;
  logic [W-1:0]  in_data_i;

  logic          in_ready_o;
  logic          out_valid_o;
  logic [W-1:0]  out_data_o;
  logic [15:0]   stall_cnt_o;

  logic          in_ready4;
  logic          out_valid4;
  logic [W-1:0]  out_data4;
  logic [3:0]    stall_cnt4;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  pipe_stage_hs #(
    .WIDTH(W),
    .CNT_W(16)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .stall_cnt_o (stall_cnt_o)
  );

  pipe_stage_hs #(
    .WIDTH(W),
    .CNT_W(4)
  ) dut4 (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready4),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid4),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data4),
    .stall_cnt_o (stall_cnt4)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [W-1:0] q[$];
  int           beats;
  int           cyc;
  logic         p_stall;
  logic         p_flush;
  logic [W-1:0] p_data;
  logic         ixfer;
  logic         oxfer;

  initial begin
    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    in_data_i   = '0;

    // 1: reset state, async reset while holding a beat
    #12;
    chk("rst_valid", out_valid_o, 1'b0);
    chk("rst_data", out_data_o, 96'h0);
    chk("rst_cnt", stall_cnt_o, 16'd0);
    chk("rst_cnt4", stall_cnt4, 4'd0);
    rst_ni = 1'b1;
    #1;
    chk("rst_ready", in_ready_o, 1'b1);
    chk("rst_ready4", in_ready4, 1'b1);
    in_valid_i  = 1'b1;
    in_data_i   = 96'h55;
    out_ready_i = 1'b0;
    tick();
    chk("pre_rst_valid", out_valid_o, 1'b1);
    chk("pre_rst_data", out_data_o, 96'h55);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", out_valid_o, 1'b0);
    chk("async_rst_data", out_data_o, 96'h0);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    #1;
    rst_ni = 1'b1;
    #1;
    chk("post_rst_ready", in_ready_o, 1'b1);

    // 2: streaming at full throughput
    for (int i = 1; i <= 8; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = W'(i);
      chk("stream_ready", in_ready_o, 1'b1);
      tick();
      chk("stream_valid", out_valid_o, 1'b1);
      chk("stream_data", out_data_o, 128'(i));
    end
    in_valid_i = 1'b0;
    tick();
    chk("stream_end_valid", out_valid_o, 1'b0);
    chk("stream_end_data", out_data_o, 96'h8);

    // 3: back-pressure hold
    in_valid_i = 1'b1;
    in_data_i  = 96'hA;
    tick();
    chk("hold_first", out_data_o, 96'hA);
    out_ready_i = 1'b0;
    in_valid_i  = 1'b0;
`ifdef PIPE_SKID_EN
    in_valid_i = 1'b1;
    in_data_i  = 96'hB;
    chk("skid_accept_ready", in_ready_o, 1'b1);
`endif
    for (int k = 1; k <= 5; k++) begin
      tick();
      in_valid_i = 1'b0;
      chk("hold_valid", out_valid_o, 1'b1);
      chk("hold_data", out_data_o, 96'hA);
      chk("hold_cnt", stall_cnt_o, 128'(k));
      chk("hold_ready", in_ready_o, 1'b0);
      if (k == 1) begin
        out_ready_i = 1'b1;
        #1;
`ifdef PIPE_SKID_EN
        chk("no_comb_path", in_ready_o, 1'b0);
`else
        chk("comb_path", in_ready_o, 1'b1);
`endif
        out_ready_i = 1'b0;
        #1;
      end
    end
    out_ready_i = 1'b1;
    tick();
`ifdef PIPE_SKID_EN
    chk("skid_second_valid", out_valid_o, 1'b1);
    chk("skid_second_data", out_data_o, 96'hB);
    chk("skid_ready_back", in_ready_o, 1'b1);
    tick();
`endif
    chk("hold_drained", out_valid_o, 1'b0);
    chk("hold_cnt_final", stall_cnt_o, 16'd5);
    chk("hold_cnt4", stall_cnt4, 4'd5);

    // 4: flush kills the beat accepted just before it and the one in flight
    in_valid_i = 1'b1;
    in_data_i  = 96'hC;
    tick();
    chk("flush_pre", out_data_o, 96'hC);
    flush_i     = 1'b1;
    in_data_i   = 96'hD;
    out_ready_i = 1'b0;
    tick();
    chk("flush_valid", out_valid_o, 1'b0);
    chk("flush_data_kept", out_data_o, 96'hC);
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    tick();
    chk("flush_no_d", out_valid_o, 1'b0);
    in_valid_i = 1'b1;
    in_data_i  = 96'hE;
    tick();
    chk("post_flush_valid", out_valid_o, 1'b1);
    chk("post_flush_data", out_data_o, 96'hE);
    in_valid_i = 1'b0;
    tick();
    chk("post_flush_drain", out_valid_o, 1'b0);
    chk("flush_cnt", stall_cnt_o, 16'd6);

    // 5: counter saturation (4-bit instance) and flush leaves it alone
    in_valid_i  = 1'b1;
    in_data_i   = 96'h5A;
    out_ready_i = 1'b0;
    tick();
    in_valid_i = 1'b0;
    chk("sat_valid", out_valid4, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 5)  chk("sat_cnt4_mid", stall_cnt4, 4'd11);
      if (k == 9)  chk("sat_cnt4_top", stall_cnt4, 4'hF);
    end
    chk("sat_cnt4", stall_cnt4, 4'hF);
    chk("sat_cnt16", stall_cnt_o, 16'd26);
    chk("sat_data4", out_data4, 96'h5A);
    flush_i = 1'b1;
    tick();
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    chk("sat_flush_valid", out_valid_o, 1'b0);
    chk("sat_flush_cnt4", stall_cnt4, 4'hF);
    chk("sat_flush_cnt16", stall_cnt_o, 16'd27);
    tick();
    chk("sat_after_cnt16", stall_cnt_o, 16'd27);

    // 6: random valid/ready/flush against a FIFO scoreboard
    beats   = 0;
    cyc     = 0;
    p_stall = 1'b0;
    p_flush = 1'b0;
    p_data  = '0;
    while (beats < 10000 && cyc < 60000) begin
      in_valid_i  = ($urandom_range(3) != 0);
      out_ready_i = ($urandom_range(3) != 0);
      flush_i     = ($urandom_range(63) == 0);
      in_data_i   = {$urandom, $urandom, $urandom};
      @(negedge clk_i);
      chk("rnd_valid", out_valid_o, (q.size() != 0));
      if (q.size() != 0) chk("rnd_data", out_data_o, q[0]);
`ifdef PIPE_SKID_EN
      chk("rnd_ready", in_ready_o, (q.size() < 2));
`else
      chk("rnd_ready", in_ready_o, (q.size() == 0) | out_ready_i);
`endif
      if (p_stall && !p_flush) begin
        chk("rnd_hold_valid", out_valid_o, 1'b1);
        chk("rnd_hold_data", out_data_o, p_data);
      end
      ixfer = in_valid_i & in_ready_o;
      oxfer = out_valid_o & out_ready_i;
      if (oxfer && q.size() != 0) void'(q.pop_front());
      if (flush_i) begin
        q.delete();
      end else if (ixfer) begin
        q.push_back(in_data_i);
        beats++;
      end
      p_stall = out_valid_o & ~out_ready_i;
      p_data  = out_data_o;
      p_flush = flush_i;
      tick();
      cyc++;
    end
    chk("rnd_beats_done", (beats >= 10000), 1'b1);
    in_valid_i  = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    tick();
    tick();
    tick();
    chk("rnd_drained", out_valid_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
